// File: rtl/wrp_shff_pkg.sv
// Shared types and helpers for the shuffle-stage transposing read sequencer.
package wrp_shff_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned SHFF_DW = 64;

    // Buffer address is {bank, row, col}.
    function automatic int unsigned addr_w(input int unsigned rows_log2,
                                           input int unsigned cols_log2);
        return rows_log2 + cols_log2 + 1;
    endfunction

endpackage

// File: rtl/wrp_shff_vpipe.sv
// Valid shift register shadowing the buffer read latency; empty when no read is in flight.
module wrp_shff_vpipe #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_v,
    output logic tail,
    output logic empty
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;

    if (DEPTH == 1) begin : g_one
        always_comb begin
            v_d = in_v;
        end
    end else begin : g_shift
        always_comb begin
            v_d = {v_q[DEPTH-2:0], in_v};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    assign tail  = v_q[DEPTH-1];
    assign empty = ~|v_q;

endmodule

// File: rtl/wrp_shff_rd_seq.sv
// Reads one frame from the ping-pong shuffle buffer in column-major order and
// pushes it into the output FIFO wrapper, throttled by the FIFO almost-full flag.
module wrp_shff_rd_seq
    import wrp_shff_pkg::*;
#(
    parameter int unsigned ROWS_LOG2 = 5,
    parameter int unsigned COLS_LOG2 = 5,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned DW        = SHFF_DW
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic                                      bank,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      mem_re,
    output logic [addr_w(ROWS_LOG2, COLS_LOG2)-1:0]   mem_addr,
    input  logic [DW-1:0]                             mem_rd,
    input  logic                                      fifo_af,
    output logic                                      fifo_we,
    output logic [DW-1:0]                             fifo_wd
);

    localparam int unsigned KW = ROWS_LOG2 + COLS_LOG2;
    localparam logic [KW-1:0] K_LAST = '1;

    state_e          state_q, state_d;
    logic            bank_q, bank_d;
    logic [KW-1:0]   k_q, k_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            fifo_we_q, fifo_we_d;
    logic [DW-1:0]   fifo_wd_q, fifo_wd_d;
    logic            issue_c;
    logic            vp_tail;
    logic            vp_empty;

    wrp_shff_vpipe #(
        .DEPTH (RD_LAT)
    ) u_vpipe (
        .clk   (clk),
        .rst_n (rst_n),
        .in_v  (issue_c),
        .tail  (vp_tail),
        .empty (vp_empty)
    );

    // Next state, read issue and output register load.
    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        k_d       = k_q;
        issue_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    bank_d  = bank;
                    k_d     = '0;
                end
            end
            RUN: begin
                // almost-full is a registered flag, so it can gate the read directly
                issue_c = !fifo_af;
                if (issue_c) begin
                    k_d = k_q + KW'(1);
                    if (k_q == K_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (vp_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        fifo_we_d = vp_tail;
        fifo_wd_d = vp_tail ? mem_rd : fifo_wd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bank_q    <= 1'b0;
            k_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fifo_we_q <= 1'b0;
            fifo_wd_q <= '0;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            k_q       <= k_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fifo_we_q <= fifo_we_d;
            fifo_wd_q <= fifo_wd_d;
        end
    end

    // Row is the fast index: low k bits select the row, high bits the column.
    assign mem_re   = issue_c;
    assign mem_addr = issue_c ? {bank_q, k_q[ROWS_LOG2-1:0], k_q[KW-1:ROWS_LOG2]} : '0;
    assign busy     = busy_q;
    assign done     = done_q;
    assign fifo_we  = fifo_we_q;
    assign fifo_wd  = fifo_wd_q;

endmodule

// File: tb/tb_wrp_shff_rd_seq.sv
// Scoreboard bench for wrp_shff_rd_seq: frame-level reference model feeds
// address/data queues that a negedge monitor drains.
module tb_wrp_shff_rd_seq;

    localparam int ROWS_LOG2 = 5;
    localparam int COLS_LOG2 = 5;
    localparam int RD_LAT    = 2;
    localparam int DW        = 64;
    localparam int ROWS      = 1 << ROWS_LOG2;
    localparam int COLS      = 1 << COLS_LOG2;
    localparam int N         = ROWS * COLS;
    localparam int AW        = ROWS_LOG2 + COLS_LOG2 + 1;
    localparam int BUDGET    = 4 * N + 200;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          bank;
    logic          busy;
    logic          done;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd;
    logic          fifo_af;
    logic          fifo_we;
    logic [DW-1:0] fifo_wd;

    int total;
    int bad;
    int n_issued;

    logic [AW-1:0] addr_q[$];
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] rd_pipe[RD_LAT];

    wrp_shff_rd_seq #(
        .ROWS_LOG2 (ROWS_LOG2),
        .COLS_LOG2 (COLS_LOG2),
        .RD_LAT    (RD_LAT),
        .DW        (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bank     (bank),
        .busy     (busy),
        .done     (done),
        .mem_re   (mem_re),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .fifo_af  (fifo_af),
        .fifo_we  (fifo_we),
        .fifo_wd  (fifo_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer content: the address in the low word, a hash of it in the high word.
    function automatic logic [DW-1:0] fdata(input logic [AW-1:0] a);
        logic [31:0] w;
        w = 32'(a);
        return {w * 32'h9E37_79B1, w};
    endfunction

    // Buffer with RD_LAT cycles of read latency.
    always @(posedge clk) begin
        rd_pipe[0] <= mem_addr;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rd = fdata(rd_pipe[RD_LAT-1]);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"},    64'(busy),     64'd0);
        chk({tag, "_done"},    64'(done),     64'd0);
        chk({tag, "_mem_re"},  64'(mem_re),   64'd0);
        chk({tag, "_addr"},    64'(mem_addr), 64'd0);
        chk({tag, "_fifo_we"}, 64'(fifo_we),  64'd0);
        chk({tag, "_fifo_wd"}, 64'(fifo_wd),  64'd0);
    endtask

    task automatic monitor_loop();
        logic [15:0]   hist;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        hist = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hist = '0;
                continue;
            end
            chk("we_latency", 64'(fifo_we), 64'(hist[RD_LAT]));
            if (fifo_af) chk("re_while_af", 64'(mem_re), 64'd0);
            if (mem_re) begin
                n_issued++;
                if (addr_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_read: addr 0x%0h with no read expected", mem_addr);
                end else begin
                    ea = addr_q.pop_front();
                    chk("rd_addr", 64'(mem_addr), 64'(ea));
                end
            end
            if (fifo_we) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_write: data 0x%0h with no write expected", fifo_wd);
                end else begin
                    ed = exp_q.pop_front();
                    chk("wr_data", fifo_wd, ed);
                end
            end
            hist = {hist[14:0], mem_re};
        end
    endtask

    // mode 0: no throttle, 1: random almost-full, 2: scripted burst at k=100 then random.
    task automatic run_frame(input logic b, input int mode, input int rst_at, input bit poke_start);
        int  base;
        int  tstep;
        bit  got_done;
        int  a;
        for (int k = 0; k < N; k++) begin
            a = int'(b) * N + (k % ROWS) * COLS + k / ROWS;
            addr_q.push_back(AW'(a));
            exp_q.push_back(fdata(AW'(a)));
        end
        base     = n_issued;
        tstep    = 0;
        got_done = 1'b0;
        fifo_af  = 1'b0;
        start    = 1'b1;
        bank     = b;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j < BUDGET; j++) begin
            bank  = 1'($urandom);
            start = poke_start && (j == 300 || j == 301);
            case (mode)
                1: fifo_af = ($urandom_range(7) == 0);
                2: begin
                    if (n_issued - base >= 100 && tstep < 60) begin
                        fifo_af = (tstep < 10) ? 1'b1 : 1'((tstep - 10) % 2 == 0);
                        tstep++;
                    end else begin
                        fifo_af = ($urandom_range(5) == 0);
                    end
                end
                default: fifo_af = 1'b0;
            endcase
            if (rst_at > 0 && n_issued - base >= rst_at) begin
                rst_n = 1'b0;
                #1;
                chk_zero_outputs("midreset");
                repeat (3) @(posedge clk);
                #1;
                addr_q.delete();
                exp_q.delete();
                fifo_af = 1'b0;
                start   = 1'b0;
                rst_n   = 1'b1;
                return;
            end
            if (done) begin
                got_done = 1'b1;
                if (mode == 0) chk("done_cycle", 64'(j + 1), 64'(N + RD_LAT + 2));
                chk("all_written", 64'(exp_q.size()), 64'd0);
                chk("issued_count", 64'(n_issued - base), 64'(N));
                break;
            end
            chk("busy_in_frame", 64'(busy), 64'd1);
            @(posedge clk); #1;
        end
        if (!got_done) begin
            total++; bad++;
            $display("FAIL done_timeout: no done within %0d cycles", BUDGET);
        end
        fifo_af = 1'b0;
        if (poke_start) begin
            start = 1'b1;
            bank  = ~b;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("done_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        n_issued = 0;
        rst_n    = 1'b0;
        start    = 1'($urandom);
        bank     = 1'($urandom);
        fifo_af  = 1'($urandom);
        #3;
        chk_zero_outputs("reset");
        start   = 1'b0;
        fifo_af = 1'b0;
        fork
            monitor_loop();
        join_none
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_frame(1'b0, 0, 0, 1'b0);
        run_frame(1'b1, 1, 0, 1'b0);
        run_frame(1'b0, 2, 0, 1'b0);
        run_frame(1'b1, 0, 0, 1'b1);
        run_frame(1'b0, 0, 0, 1'b0);
        run_frame(1'b1, 1, 500, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("post_reset_busy", 64'(busy), 64'd0);
        run_frame(1'b0, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
